// File: rtl/frac_div_ctrl.sv
// rtl/frac_div_ctrl.sv - pulse-swallow controller for a fractional-N feedback divider
module frac_div_ctrl #(
    parameter int CNT_W  = 8,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_p_cnt,
    input  logic [CNT_W-1:0]  cfg_s_cnt,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              mod_ctrl,
    output logic              div_out,
    output logic              frac_carry,
    output logic              running
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  p_act_q, p_act_d, s_act_q, s_act_d;
    logic [CNT_W-1:0]  pend_p_q, pend_p_d, pend_s_q, pend_s_d;
    logic [FRAC_W-1:0] frac_act_q, frac_act_d, pend_f_q, pend_f_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              pend_q, pend_d;
    logic              ready_q, ready_d;

    logic              is_run, boundary, xfer, load;
    logic [CNT_W-1:0]  p_last, p_clamp, s_clamp;
    logic [CNT_W:0]    s_sum, s_eff;
    logic [FRAC_W:0]   acc_sum;

    assign is_run   = (state_q == S_RUN);
    assign p_last   = p_act_q - ONE;
    assign boundary = is_run && (cnt_q == p_last);
    assign xfer     = cfg_valid && ready_q;
    // Pending config lands only between periods so no runt period reaches the PFD.
    assign load     = pend_q && (!is_run || boundary);

    assign p_clamp  = (pend_p_q < TWO) ? TWO : pend_p_q;
    assign s_clamp  = (pend_s_q > p_clamp) ? p_clamp : pend_s_q;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_act_q};
    assign s_sum    = {1'b0, s_act_q} + {{CNT_W{1'b0}}, carry_q};
    assign s_eff    = (s_sum > {1'b0, p_act_q}) ? {1'b0, p_act_q} : s_sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en && (p_act_q >= TWO)) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running    = is_run;
        div_out    = boundary;
        mod_ctrl   = is_run && ({1'b0, cnt_q} < s_eff);
        frac_carry = carry_q;
        cfg_ready  = ready_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        p_act_d    = p_act_q;
        s_act_d    = s_act_q;
        frac_act_d = frac_act_q;
        pend_p_d   = pend_p_q;
        pend_s_d   = pend_s_q;
        pend_f_d   = pend_f_q;
        pend_d     = pend_q;

        if (load) begin
            p_act_d    = p_clamp;
            s_act_d    = s_clamp;
            frac_act_d = pend_f_q;
            pend_d     = 1'b0;
        end
        if (xfer) begin
            pend_p_d = cfg_p_cnt;
            pend_s_d = cfg_s_cnt;
            pend_f_d = cfg_frac;
            pend_d   = 1'b1;
        end

        // The carry from this boundary uses the frac of the period that is ending.
        if (is_run && !en) begin
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (boundary) begin
            cnt_d            = '0;
            {carry_d, acc_d} = acc_sum;
        end else if (is_run) begin
            cnt_d = cnt_q + ONE;
        end

        ready_d = !pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            p_act_q    <= '0;
            s_act_q    <= '0;
            frac_act_q <= '0;
            pend_p_q   <= '0;
            pend_s_q   <= '0;
            pend_f_q   <= '0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            p_act_q    <= p_act_d;
            s_act_q    <= s_act_d;
            frac_act_q <= frac_act_d;
            pend_p_q   <= pend_p_d;
            pend_s_q   <= pend_s_d;
            pend_f_q   <= pend_f_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_frac_div_ctrl.sv
// tb/tb_frac_div_ctrl.sv - self-checking bench for frac_div_ctrl
module tb_frac_div_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, cfg_valid;
    logic [7:0]  cfg_p_cnt, cfg_s_cnt;
    logic [15:0] cfg_frac;
    logic        cfg_ready, mod_ctrl, div_out, frac_carry, running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frac_div_ctrl #(.CNT_W(8), .FRAC_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_p_cnt(cfg_p_cnt), .cfg_s_cnt(cfg_s_cnt), .cfg_frac(cfg_frac),
        .mod_ctrl(mod_ctrl), .div_out(div_out), .frac_carry(frac_carry), .running(running)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Behavioural model: period position, phase accumulator and config mailbox as plain integers.
    bit m_on = 0, m_run = 0, m_carry = 0, m_pend = 0, m_rdy = 0;
    int m_cnt = 0, m_acc = 0, m_p = 0, m_s = 0, m_f = 0, m_pp = 0, m_ps = 0, m_pf = 0;

    always @(posedge clk) begin : model
        bit xfer, bnd, load;
        if (!rst) begin
            m_on = 1; m_run = 0; m_carry = 0; m_pend = 0; m_rdy = 0;
            m_cnt = 0; m_acc = 0; m_p = 0; m_s = 0; m_f = 0;
            m_pp = 0; m_ps = 0; m_pf = 0;
        end else begin
            xfer = cfg_valid && m_rdy;
            bnd  = m_run && (m_cnt == m_p - 1);
            load = m_pend && (!m_run || bnd);
            if (m_run) begin
                if (!en) begin
                    m_run = 0; m_cnt = 0; m_acc = 0; m_carry = 0;
                end else if (bnd) begin
                    m_acc   = m_acc + m_f;
                    m_carry = (m_acc >= 65536);
                    m_acc   = m_acc % 65536;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end else if (en && m_p >= 2) begin
                m_run = 1; m_cnt = 0;
            end
            if (load) begin
                m_p = imax(m_pp, 2); m_s = imin(m_ps, m_p); m_f = m_pf; m_pend = 0;
            end
            if (xfer) begin
                m_pp = cfg_p_cnt; m_ps = cfg_s_cnt; m_pf = cfg_frac; m_pend = 1;
            end
            m_rdy = !m_pend;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("running",    running,    m_run);
            chk("div_out",    div_out,    m_run && (m_cnt == m_p - 1));
            chk("mod_ctrl",   mod_ctrl,   m_run && (m_cnt < imin(m_s + m_carry, m_p)));
            chk("frac_carry", frac_carry, m_carry);
            chk("cfg_ready",  cfg_ready,  m_rdy);
        end
    end

    // Called on a negedge; returns on the negedge just after the transfer edge.
    task automatic offer(input int p, input int s, input int f);
        cfg_p_cnt = 8'(p); cfg_s_cnt = 8'(s); cfg_frac = 16'(f); cfg_valid = 1'b1;
        for (int i = 0; i < 60 && !cfg_ready; i++) @(negedge clk);
        chk("offer_accept_timeout", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Returns on the negedge of the first cycle (cnt=0) of the next period.
    task automatic sync_start();
        for (int i = 0; i < 300 && !div_out; i++) @(negedge clk);
        chk("sync_timeout", div_out, 1);
        @(negedge clk);
    endtask

    // Starts on a period's first cycle, ends on the next period's first cycle.
    task automatic measure(output int len, output int mods, output int car);
        logic d;
        len = 0; mods = 0; car = 0;
        for (int i = 0; i < 300; i++) begin
            d = div_out;
            len++;
            mods += int'(mod_ctrl);
            car = int'(frac_carry);
            @(negedge clk);
            if (d) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len, mods, car, csum, msum;
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        cfg_p_cnt = '0; cfg_s_cnt = '0; cfg_frac = '0;
        repeat (3) @(negedge clk);
        chk("rst_running", running, 0);
        chk("rst_mod", mod_ctrl, 0);
        chk("rst_div", div_out, 0);
        chk("rst_ready", cfg_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", cfg_ready, 1);

        // p=5 s=2 frac=0
        en = 1'b1;
        @(negedge clk);
        chk("t1_idle_without_cfg", running, 0);
        offer(5, 2, 0);
        chk("t1_ready_low_after_xfer", cfg_ready, 0);
        @(negedge clk);
        chk("t1_ready_back", cfg_ready, 1);
        sync_start();
        for (int k = 0; k < 3; k++) begin
            measure(len, mods, car);
            chk("t1_len", len, 5);
            chk("t1_mods", mods, 2);
            chk("t1_carry", car, 0);
        end

        // frac=0x4000: one carry period in four
        offer(5, 2, 16'h4000);
        sync_start();
        sync_start();
        csum = 0; msum = 0;
        for (int k = 0; k < 8; k++) begin
            measure(len, mods, car);
            chk("t2_len", len, 5);
            chk("t2_mods", mods, 2 + car);
            csum += car; msum += mods;
        end
        chk("t2_carry_count", csum, 2);
        chk("t2_mod_total", msum, 18);

        // reconfigure at cnt=2 of a running period
        @(negedge clk);
        @(negedge clk);
        offer(8, 1, 0);
        chk("t3_ready_low", cfg_ready, 0);
        chk("t3_no_early_div", div_out, 0);
        @(negedge clk);
        chk("t3_old_period_end", div_out, 1);
        chk("t3_ready_still_low", cfg_ready, 0);
        @(negedge clk);
        chk("t3_ready_at_boundary", cfg_ready, 1);
        measure(len, mods, car);
        chk("t3_len_a", len, 8);
        chk("t3_mods_a", mods, 1 + car);
        measure(len, mods, car);
        chk("t3_len_b", len, 8);
        chk("t3_mods_b", mods, 1);
        chk("t3_carry_b", car, 0);

        // clamping and saturation
        offer(1, 9, 0);
        sync_start();
        sync_start();
        measure(len, mods, car);
        chk("t4_clamp_len", len, 2);
        chk("t4_clamp_mods", mods, 2);
        offer(3, 3, 16'h8000);
        sync_start();
        sync_start();
        csum = 0;
        for (int k = 0; k < 4; k++) begin
            measure(len, mods, car);
            chk("t4_sat_len", len, 3);
            chk("t4_sat_mods", mods, 3);
            csum += car;
        end
        chk("t4_carry_count", csum, 2);

        // disable mid-period, reconfigure while idle, re-enable
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("t5_stopped", running, 0);
        chk("t5_mod_low", mod_ctrl, 0);
        chk("t5_carry_clear", frac_carry, 0);
        offer(4, 1, 0);
        en = 1'b1;
        @(negedge clk);
        chk("t5_restart", running, 1);
        chk("t5_mod_cnt0", mod_ctrl, 1);
        chk("t5_carry_restart", frac_carry, 0);
        chk("t5_ready", cfg_ready, 1);
        measure(len, mods, car);
        chk("t5_len", len, 4);
        chk("t5_mods", mods, 1);

        // reset mid-run
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_running", running, 0);
        chk("t6_mod", mod_ctrl, 0);
        chk("t6_div", div_out, 0);
        chk("t6_ready", cfg_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_ready_release", cfg_ready, 1);
        repeat (3) @(negedge clk);
        chk("t6_idle_no_cfg", running, 0);
        offer(6, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_run_after_cfg", running, 1);
        measure(len, mods, car);
        chk("t6_len", len, 6);
        chk("t6_mods", mods, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
